// File: rtl/himpp_pkg.sv
// Shared parameters, types and field-placement helper for the hit-info memory controller.
package himpp_pkg;
  localparam int ROWINDEXBITS_HIM = 10;
  localparam int NCOLS_HIM        = 64;
  localparam int HITINFOBITS      = 16;
  localparam int MAXHITNBITS      = 3;
  localparam int QUEUESIZE        = 4;
  localparam int BRAM_READDELAY   = 2;
  localparam int SLOTS            = NCOLS_HIM / HITINFOBITS;
  localparam int WAITBITS         = $clog2(BRAM_READDELAY + 1);
  localparam int CNTBITS          = $clog2(QUEUESIZE + 1);

  typedef logic [ROWINDEXBITS_HIM-1:0] row_t;
  typedef logic [NCOLS_HIM-1:0]        data_t;
  typedef logic [MAXHITNBITS-1:0]      nhit_t;

  typedef struct packed {
    row_t                row;
    nhit_t               n_old;
    nhit_t               n_new;
    data_t               info;
    logic [WAITBITS-1:0] wait_cnt;
  } wq_entry_t;

  // Moves packed fields up to start at the given slot; fields past the row top are dropped.
  function automatic data_t place_fields(data_t info, nhit_t slot);
    data_t res;
    if (int'(slot) >= SLOTS) res = '0;
    else                     res = info << (int'(slot) * HITINFOBITS);
    return res;
  endfunction
endpackage

// File: rtl/himpp_if.sv
// Request/response bundle between the clustering front end, readers and himpp_ctrl.
interface himpp_if;
  import himpp_pkg::*;

  logic  writeRow;
  row_t  inputRowToWrite;
  nhit_t nOldHits;
  nhit_t nNewHits;
  data_t inputHitInfo;
  logic  readRow;
  row_t  inputRowToRead;
  logic  writeReady;
  logic  readReady;
  logic  busy;
  data_t rowData;
  row_t  rowDataRow;
  logic  rowDataValid;

  modport master (
    output writeRow, inputRowToWrite, nOldHits, nNewHits, inputHitInfo, readRow, inputRowToRead,
    input  writeReady, readReady, busy, rowData, rowDataRow, rowDataValid
  );

  modport slave (
    input  writeRow, inputRowToWrite, nOldHits, nNewHits, inputHitInfo, readRow, inputRowToRead,
    output writeReady, readReady, busy, rowData, rowDataRow, rowDataValid
  );
endinterface

// File: rtl/himpp_ram.sv
// Simple dual-port row RAM: port A writes, port B reads with BRAM_READDELAY cycles of latency.
module himpp_ram
  import himpp_pkg::*;
(
  input  logic  clk,
  input  logic  we_i,
  input  row_t  waddr_i,
  input  data_t wdata_i,
  input  row_t  raddr_i,
  output data_t rdata_o
);
  localparam int DEPTH = 1 << ROWINDEXBITS_HIM;

  data_t mem [DEPTH];
  data_t rd_pipe_q [BRAM_READDELAY];

  // Same-address write and read on one edge returns the old contents.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rd_pipe_q[0] <= mem[raddr_i];
    for (int i = 1; i < BRAM_READDELAY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
  end

  assign rdata_o = rd_pipe_q[BRAM_READDELAY-1];
endmodule

// File: rtl/himpp_ctrl.sv
// Hit-info memory controller: merged read-modify-write appends into row RAM plus
// forwarded row reads, one request per cycle.
module himpp_ctrl
  import himpp_pkg::*;
(
  input logic   clk,
  input logic   reset,
  himpp_if.slave hif
);
  localparam logic [CNTBITS-1:0]  CNT_ONE  = CNTBITS'(1);
  localparam logic [WAITBITS-1:0] WAIT_ONE = WAITBITS'(1);

  wq_entry_t            q_q [QUEUESIZE];
  wq_entry_t            q_d [QUEUESIZE];
  logic [CNTBITS-1:0]   cnt_q, cnt_d;

  logic                 req_rd_q;
  row_t                 req_row_q;
  logic [BRAM_READDELAY-1:0] tag_vld_q;
  row_t                 tag_row_q [BRAM_READDELAY];
  logic [BRAM_READDELAY-1:0] hist_vld_q;
  row_t                 hist_row_q [BRAM_READDELAY];
  data_t                hist_data_q [BRAM_READDELAY];

  logic                 out_vld_q;
  data_t                out_data_q;
  row_t                 out_row_q;

  logic                 write_ready, read_ready, wr_acc, rd_acc, pop, merge_any;
  logic [QUEUESIZE-1:0] merge_hit;
  wq_entry_t            head;
  data_t                ram_rdata, fwd_rdata, commit_data;
  row_t                 data_row;

  assign head        = q_q[0];
  assign pop         = (cnt_q != '0) && (head.wait_cnt == '0);
  assign write_ready = (cnt_q - CNTBITS'(pop)) < CNTBITS'(QUEUESIZE);
  assign read_ready  = !hif.writeRow;
  assign wr_acc      = hif.writeRow && write_ready;
  assign rd_acc      = hif.readRow && read_ready;
  assign data_row    = tag_row_q[BRAM_READDELAY-1];

  // Only entries whose RAM write is still ahead may absorb a new append.
  for (genvar gi = 0; gi < QUEUESIZE; gi++) begin : g_merge
    assign merge_hit[gi] = (CNTBITS'(gi) < cnt_q) && (q_q[gi].row == hif.inputRowToWrite)
                           && (q_q[gi].wait_cnt != '0);
  end
  assign merge_any = |merge_hit;

  // RAM data misses writes committed after its read edge; newest committed write wins.
  always_comb begin
    fwd_rdata = ram_rdata;
    for (int i = BRAM_READDELAY - 1; i >= 0; i--) begin
      if (hist_vld_q[i] && (hist_row_q[i] == data_row)) fwd_rdata = hist_data_q[i];
    end
  end

  assign commit_data = (head.n_old == '0) ? head.info
                                          : (fwd_rdata | place_fields(head.info, head.n_old));

  always_comb begin
    for (int i = 0; i < QUEUESIZE; i++) begin
      q_d[i] = q_q[i];
      if (wr_acc && merge_hit[i]) begin
        if (hif.nOldHits == '0) begin
          q_d[i].n_old = '0;
          q_d[i].info  = hif.inputHitInfo;
        end else begin
          q_d[i].info = q_q[i].info
                        | place_fields(hif.inputHitInfo, nhit_t'(hif.nOldHits - q_q[i].n_old));
        end
        q_d[i].n_new = q_q[i].n_new + hif.nNewHits;
      end
      if (q_d[i].wait_cnt != '0) q_d[i].wait_cnt = q_d[i].wait_cnt - WAIT_ONE;
    end
    if (pop) begin
      for (int i = 0; i < QUEUESIZE - 1; i++) q_d[i] = q_d[i+1];
    end
    cnt_d = cnt_q - CNTBITS'(pop);
    if (wr_acc && !merge_any) begin
      for (int i = 0; i < QUEUESIZE; i++) begin
        if (CNTBITS'(i) == cnt_d) begin
          q_d[i].row      = hif.inputRowToWrite;
          q_d[i].n_old    = hif.nOldHits;
          q_d[i].n_new    = hif.nNewHits;
          q_d[i].info     = hif.inputHitInfo;
          q_d[i].wait_cnt = WAITBITS'(BRAM_READDELAY);
        end
      end
      cnt_d = cnt_d + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < QUEUESIZE; i++) q_q[i] <= '0;
      for (int i = 0; i < BRAM_READDELAY; i++) begin
        tag_row_q[i]   <= '0;
        hist_row_q[i]  <= '0;
        hist_data_q[i] <= '0;
      end
      cnt_q      <= '0;
      req_rd_q   <= 1'b0;
      req_row_q  <= '0;
      tag_vld_q  <= '0;
      hist_vld_q <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_row_q  <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      if (wr_acc)      req_row_q <= hif.inputRowToWrite;
      else if (rd_acc) req_row_q <= hif.inputRowToRead;
      req_rd_q <= rd_acc;
      tag_vld_q[0]   <= req_rd_q;
      tag_row_q[0]   <= req_row_q;
      hist_vld_q[0]  <= pop;
      hist_row_q[0]  <= head.row;
      hist_data_q[0] <= commit_data;
      for (int i = 1; i < BRAM_READDELAY; i++) begin
        tag_vld_q[i]   <= tag_vld_q[i-1];
        tag_row_q[i]   <= tag_row_q[i-1];
        hist_vld_q[i]  <= hist_vld_q[i-1];
        hist_row_q[i]  <= hist_row_q[i-1];
        hist_data_q[i] <= hist_data_q[i-1];
      end
      out_vld_q <= tag_vld_q[BRAM_READDELAY-1];
      if (tag_vld_q[BRAM_READDELAY-1]) begin
        out_data_q <= fwd_rdata;
        out_row_q  <= data_row;
      end
    end
  end

  logic commit_we;
  assign commit_we = pop;

  himpp_ram u_ram (
    .clk     (clk),
    .we_i    (commit_we),
    .waddr_i (head.row),
    .wdata_i (commit_data),
    .raddr_i (req_row_q),
    .rdata_o (ram_rdata)
  );

  assign hif.writeReady   = write_ready;
  assign hif.readReady    = read_ready;
  assign hif.busy         = (cnt_q != '0) || req_rd_q || (|tag_vld_q);
  assign hif.rowData      = out_data_q;
  assign hif.rowDataRow   = out_row_q;
  assign hif.rowDataValid = out_vld_q;
endmodule

// File: tb/tb_himpp_ctrl.sv
// Scoreboard bench for himpp_ctrl: reads push expected rows, a negedge monitor pops on rowDataValid.
module tb_himpp_ctrl;
  import himpp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_run = 0;
  int   n_fail = 0;
  int   cyc_cnt = 0;
  int   ram_writes = 0;

  typedef struct {
    row_t  row;
    data_t data;
    int    due;
  } exp_t;
  exp_t exp_q[$];

  himpp_if hif();

  himpp_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rowDataValid must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (dut.commit_we && reset) ram_writes++;
    if (reset && hif.rowDataValid) begin
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_read: got row %0d data %h expected no result", hif.rowDataRow, hif.rowData);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_data", 64'(hif.rowData), 64'(e.data));
        check("rd_row", 64'(hif.rowDataRow), 64'(e.row));
        check("rd_latency", 64'(cyc_cnt), 64'(e.due));
        $display("[TB] read row %0d data %h at cycle %0d", hif.rowDataRow, hif.rowData, cyc_cnt);
      end
    end
  end

  task automatic idle();
    hif.writeRow = 1'b0;
    hif.readRow  = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle();
    end
  endtask

  task automatic do_write(input int row, input int n_old, input int n_new, input data_t info);
    @(negedge clk);
    idle();
    hif.writeRow        = 1'b1;
    hif.inputRowToWrite = row_t'(row);
    hif.nOldHits        = nhit_t'(n_old);
    hif.nNewHits        = nhit_t'(n_new);
    hif.inputHitInfo    = info;
    $display("[TB] write row %0d nOld %0d info %h", row, n_old, info);
  endtask

  task automatic do_read(input int row, input data_t exp_data, input bit expect_result);
    exp_t e;
    @(negedge clk);
    idle();
    hif.readRow        = 1'b1;
    hif.inputRowToRead = row_t'(row);
    if (expect_result) begin
      e.row  = row_t'(row);
      e.data = exp_data;
      e.due  = cyc_cnt + 4;
      exp_q.push_back(e);
    end
    $display("[TB] read request row %0d", row);
  endtask

  initial begin
    int w0;
    reset = 1'b0;
    idle();
    hif.inputRowToWrite = '0;
    hif.inputRowToRead  = '0;
    hif.nOldHits        = '0;
    hif.nNewHits        = '0;
    hif.inputHitInfo    = '0;
    repeat (3) @(negedge clk);
    check("rst_writeReady", 64'(hif.writeReady), 64'd1);
    check("rst_readReady", 64'(hif.readReady), 64'd1);
    check("rst_busy", 64'(hif.busy), 64'd0);
    check("rst_valid", 64'(hif.rowDataValid), 64'd0);
    check("rst_rowData", 64'(hif.rowData), 64'd0);
    check("rst_rowDataRow", 64'(hif.rowDataRow), 64'd0);
    reset = 1'b1;

    // Basic write then read.
    do_write(5, 0, 1, 64'h000A);
    step(5);
    do_read(5, 64'h000A, 1'b1);
    step(7);
    check("idle_busy", 64'(hif.busy), 64'd0);

    // Back-to-back appends to one row merge into a single RAM write.
    w0 = ram_writes;
    do_write(5, 0, 1, 64'h1);
    do_write(5, 1, 1, 64'h2);
    step(6);
    check("merge_ram_writes", 64'(ram_writes - w0), 64'd1);
    do_read(5, 64'h0000_0000_0002_0001, 1'b1);
    step(5);

    // Merge where the second request clears the row.
    do_write(11, 0, 1, 64'h7);
    do_write(11, 0, 1, 64'h9);
    step(5);
    do_read(11, 64'h9, 1'b1);
    step(5);

    // Reads right after a write are forwarded, including the same-cycle RAM write/read.
    do_write(7, 0, 1, 64'h3);
    do_read(7, 64'h3, 1'b1);
    do_read(7, 64'h3, 1'b1);
    do_read(7, 64'h3, 1'b1);
    step(6);

    // Read-modify-write append from RAM, and an append into the top slot.
    do_write(7, 1, 1, 64'h0044);
    do_write(5, 3, 1, 64'hBEEF);
    step(5);
    do_read(7, 64'h0000_0000_0044_0003, 1'b1);
    do_read(5, 64'hBEEF_0000_0002_0001, 1'b1);
    step(5);

    // nOldHits beyond the last slot leaves the row unchanged.
    do_write(5, 4, 1, 64'hFFFF);
    step(5);
    do_read(5, 64'hBEEF_0000_0002_0001, 1'b1);
    step(5);

    // Write and read together: read is refused, write proceeds.
    do_write(9, 0, 1, 64'h55);
    hif.readRow        = 1'b1;
    hif.inputRowToRead = row_t'(9);
    #1;
    check("both_readReady", 64'(hif.readReady), 64'd0);
    check("both_writeReady", 64'(hif.writeReady), 64'd1);
    step(5);
    do_read(9, 64'h55, 1'b1);
    step(5);

    // Sustained writes to distinct rows.
    for (int i = 0; i < 20; i++) begin
      do_write(100 + i, 0, 1, 64'(32'h1000 + i));
      #1;
      check("stream_writeReady", 64'(hif.writeReady), 64'd1);
    end
    step(5);
    for (int i = 0; i < 20; i++) do_read(100 + i, 64'(32'h1000 + i), 1'b1);
    step(6);

    // Reset mid-stream discards the queued write and the in-flight read.
    do_write(100, 0, 1, 64'hDEAD);
    do_read(101, 64'h0, 1'b0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(hif.rowDataValid), 64'd0);
    check("mid_rst_rowData", 64'(hif.rowData), 64'd0);
    check("mid_rst_rowDataRow", 64'(hif.rowDataRow), 64'd0);
    check("mid_rst_busy", 64'(hif.busy), 64'd0);
    check("mid_rst_writeReady", 64'(hif.writeReady), 64'd1);
    check("mid_rst_readReady", 64'(hif.readReady), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    step(4);
    do_read(100, 64'h1000, 1'b1);
    do_read(101, 64'h1001, 1'b1);
    step(8);
    check("pending_reads", 64'(exp_q.size()), 64'd0);
    check("final_busy", 64'(hif.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/himpp_ctrl.md
# himpp_ctrl

Hit-info memory controller: stores per-row hit words in a dual-port block RAM and performs read-modify-write appends of new hit fields into rows, one request per cycle. It sits between the hit-clustering front end, which issues row writes with hit counts, and downstream readers, which fetch whole rows. Pending writes to the same row are merged. Reads and merged writes always observe every previously accepted write, through forwarding.

## Interface
- ROWINDEXBITS_HIM, 10: row address width (depth 2^ROWINDEXBITS_HIM).
- NCOLS_HIM, 64: row width in bits.
- HITINFOBITS, 16: width of one hit field; slots per row = NCOLS_HIM/HITINFOBITS.
- MAXHITNBITS, 3: width of hit-count inputs.
- QUEUESIZE, 4: pending-write queue depth; must be ≥ BRAM_READDELAY+2.
- BRAM_READDELAY, 2: RAM read latency in cycles.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-low (0 = reset).
- writeRow  in  1  append request.
- inputRowToWrite  in  ROWINDEXBITS_HIM  target row of append.
- nOldHits  in  MAXHITNBITS  hits already in row = slot index of first new field.
- nNewHits  in  MAXHITNBITS  number of fields in inputHitInfo.
- inputHitInfo  in  NCOLS_HIM  new fields packed from bit 0.
- readRow  in  1  row read request.
- inputRowToRead  in  ROWINDEXBITS_HIM  row to read.
- writeReady  out  1  write queue can accept a writeRow.
- readReady  out  1  a readRow will be accepted this cycle.
- busy  out  1  any request pending or in flight.
- rowData  out  NCOLS_HIM  read result.
- rowDataRow  out  ROWINDEXBITS_HIM  row of rowData.
- rowDataValid  out  1  one-cycle strobe qualifying rowData.

## Operation
- Append semantics: if nOldHits==0 new row = inputHitInfo (row cleared); else new row = old | (inputHitInfo << nOldHits*HITINFOBITS). Bits shifted beyond NCOLS_HIM are discarded.
- Accepted writeRow issues a RAM read of the row and enqueues an entry {row, nOld, nNew, info, wait=BRAM_READDELAY}.
- Merge: a writeRow whose row matches a queued entry whose RAM write has not yet been issued creates no new entry. It is applied to that entry per the append rule, in request order: entry.info |= inputHitInfo << (nOldHits−entry.nOld)*HITINFOBITS; entry.nNew += nNewHits. If nOldHits==0, the entry becomes {nOld=0, info=inputHitInfo}.
- Coherence: every read result and every committed write reflects all writeRow requests accepted in earlier cycles. RAM data for a row with a write committed during the read window is replaced by forwarded data; the latest write wins.
- writeRow has priority over readRow. A readRow in the same cycle is ignored and readReady=0 while writeRow is high.
- Requests are dropped when the corresponding ready signal is low.
- writeReady = write-queue occupancy after this cycle's pop < QUEUESIZE.
- busy = either queue non-empty.

## Timing
- Request accepted at cycle t (sampled on the clk edge).
- Read: rowDataValid=1 at t+BRAM_READDELAY+1 with rowData/rowDataRow; 1 request/cycle sustained.
- Write: RAM write enable at t+BRAM_READDELAY+1. A merged request does not extend the original entry's timing.
- Write and read of the same row in the same cycle: the read returns post-write data.
- Reset values: writeReady=1, readReady=1, busy=0, rowDataValid=0, rowData=0, rowDataRow=0, queues empty, no RAM write pending.
- Reset mid-operation discards queued writes and in-flight reads. RAM contents are not cleared.

## Structure
- Package himpp_pkg: the six parameters, derived SLOTS=NCOLS_HIM/HITINFOBITS, and the queue-entry struct {row, nOld, nNew, info, wait}.
- Sub-module himpp_ram: simple dual-port RAM with port A write and port B read, latency BRAM_READDELAY, no reset.
- Top: write queue with merge compare, read-tag pipeline, forwarding compare, ready/busy logic.

## Test plan
- Reset, then writeRow row 5, nOld=0, info=0x000A. Then readRow 5 after 5 cycles. Expected: rowDataValid at read+3 with rowData=0x000A; busy=0 afterwards.
- Back-to-back writeRow to row 5 at t (nOld=0, info=0x1) and t+1 (nOld=1, info=0x2), then read. Expected: 0x0002_0001, and only one RAM write issued (merged).
- writeRow row 7 (nOld=0, info=0x3) at t, readRow 7 at t+1 and at t+3. Expected: both reads return 0x0003 (forwarding).
- nOldHits=4 with 64-bit rows and 16-bit fields. Expected: row unchanged (data shifted out).
- writeRow and readRow both high in one cycle. Expected: readReady=0, read dropped, write performed.
- Continuous writeRow to distinct rows for 20 cycles. Expected: writeReady stays 1 and all rows read back correctly; assert reset mid-stream and check the outputs reach their reset values.
